// File: rtl/poly_arith_pkg.sv
// Shared types and constants for the ML-KEM polynomial arithmetic blocks.
//   coeff_t : one 12-bit coefficient
//   Q       : ML-KEM modulus
//   N_COEFF : coefficients per polynomial
package poly_arith_pkg;

  typedef logic [11:0] coeff_t;

  localparam coeff_t Q       = 12'd3329;
  localparam int     N_COEFF = 256;

  // True when a coefficient is a canonical residue mod Q.
  function automatic logic in_range(input coeff_t c);
    return (c < Q);
  endfunction

endpackage

// File: rtl/pointwise_mul_ctrl.sv
// Pointwise multiply sequencer: streams a[i], b[i] from two synchronous
// operand memories into an external mod_mul pipeline and writes the returned
// products c[i] = a[i]*b[i] mod Q back to the result memory in order.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   start_i           : job request, sampled only in IDLE
//   busy_o, done_o    : job in progress / one-cycle completion pulse
//   err_o             : sticky error (range, protocol, watchdog); cleared on start
//   rd_en_o, rd_addr_o: operand memory read port (data returns next cycle)
//   rd_a_i, rd_b_i    : operand read data
//   mul_op1_o/op2_o   : operands to mod_mul, zero when mul_valid_o is low
//   mul_valid_o       : operand valid to mod_mul
//   mul_result_i/valid_i : product and valid from mod_mul
//   wr_en_o, wr_addr_o, wr_data_o : result memory write port
//
// state  | meaning
// IDLE   | waiting for start_i
// ISSUE  | one read per cycle, addresses 0..N-1
// DRAIN  | all reads issued, waiting for the last products
// DONE   | one-cycle done pulse, then back to IDLE
module pointwise_mul_ctrl
  import poly_arith_pkg::*;
#(
  parameter int N       = N_COEFF,
  parameter int MUL_LAT = 3,
  parameter int ADDR_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  coeff_t            rd_a_i,
  input  coeff_t            rd_b_i,
  output coeff_t            mul_op1_o,
  output coeff_t            mul_op2_o,
  output logic              mul_valid_o,
  input  coeff_t            mul_result_i,
  input  logic              mul_valid_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output coeff_t            wr_data_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  // Counters carry one extra bit so the terminal value N does not wrap.
  localparam int CNT_W  = ADDR_W + 1;
  localparam int WD_LIM = N + MUL_LAT + 4;
  localparam int WD_W   = $clog2(WD_LIM + 1);

  localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(WD_LIM);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic              err_q;
  logic              mul_valid_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  coeff_t            wr_data_q;

  logic active;
  logic start_ok;
  logic wd_expired;
  logic range_hit;
  logic wr_accept;
  logic proto_err;

  always_comb begin
    active     = (state == S_ISSUE) || (state == S_DRAIN);
    start_ok   = (state == S_IDLE) && start_i;
    // Watchdog down-counter reached terminal count while products are missing.
    wd_expired = active && (wd_cnt == '0) && (wr_cnt < CNT_N);
    range_hit  = mul_valid_q && !(in_range(rd_a_i) && in_range(rd_b_i));
    // A product is written only inside a job and only up to N of them;
    // anything else is stray (e.g. in flight across a reset) and is dropped.
    wr_accept  = mul_valid_i && active && (wr_cnt < CNT_N);
    proto_err  = mul_valid_i && !wr_accept;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_i) state_nxt = S_ISSUE;
      S_ISSUE: if (issue_cnt == CNT_LAST) state_nxt = S_DRAIN;
      S_DRAIN: if (wr_cnt == CNT_N) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (wd_expired) state_nxt = S_DONE;
  end

  always_comb begin
    busy_o      = active;
    done_o      = (state == S_DONE);
    rd_en_o     = (state == S_ISSUE);
    rd_addr_o   = rd_en_o ? issue_cnt[ADDR_W-1:0] : '0;
    mul_valid_o = mul_valid_q;
    mul_op1_o   = mul_valid_q ? rd_a_i : '0;
    mul_op2_o   = mul_valid_q ? rd_b_i : '0;
    // Out-of-range operands are flagged in the very cycle they reach mod_mul.
    err_o       = err_q | range_hit;
    wr_en_o     = wr_en_q;
    wr_addr_o   = wr_addr_q;
    wr_data_o   = wr_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt   <= '0;
      wr_cnt      <= '0;
      wd_cnt      <= '0;
      err_q       <= 1'b0;
      mul_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      mul_valid_q <= rd_en_o;

      if (start_ok) begin
        issue_cnt <= '0;
      end else if (rd_en_o) begin
        issue_cnt <= issue_cnt + 1'b1;
      end

      if (start_ok) begin
        wr_cnt <= '0;
      end else if (wr_accept) begin
        wr_cnt <= wr_cnt + 1'b1;
      end

      if (start_ok) begin
        wd_cnt <= WD_LOAD;
      end else if (active && (wd_cnt != '0)) begin
        wd_cnt <= wd_cnt - 1'b1;
      end

      // A fresh error wins over the clear from a simultaneous start.
      if (range_hit || proto_err || wd_expired) begin
        err_q <= 1'b1;
      end else if (start_ok) begin
        err_q <= 1'b0;
      end

      wr_en_q   <= wr_accept;
      wr_addr_q <= wr_accept ? wr_cnt[ADDR_W-1:0] : '0;
      wr_data_q <= wr_accept ? mul_result_i : '0;
    end
  end

endmodule

// File: tb/tb_pointwise_mul_ctrl.sv
module tb_pointwise_mul_ctrl;
  import poly_arith_pkg::*;

  localparam int N       = 256;
  localparam int MUL_LAT = 3;
  localparam int AW      = 8;
  localparam int QI      = 3329;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          busy_o, done_o, err_o, rd_en_o, mul_valid_o, mul_valid_i, wr_en_o;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  coeff_t        rd_a_i, rd_b_i, mul_op1_o, mul_op2_o, mul_result_i, wr_data_o;

  pointwise_mul_ctrl #(.N(N), .MUL_LAT(MUL_LAT), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .rd_a_i       (rd_a_i),
    .rd_b_i       (rd_b_i),
    .mul_op1_o    (mul_op1_o),
    .mul_op2_o    (mul_op2_o),
    .mul_valid_o  (mul_valid_o),
    .mul_result_i (mul_result_i),
    .mul_valid_i  (mul_valid_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand memories: synchronous read.
  coeff_t mem_a [N];
  coeff_t mem_b [N];
  always @(posedge clk) begin
    if (rd_en_o) begin
      rd_a_i <= mem_a[rd_addr_o];
      rd_b_i <= mem_b[rd_addr_o];
    end
  end

  // Behavioural mod_mul, MUL_LAT stages, not tied to the DUT reset.
  logic       kill = 1'b0;
  logic [2:0] pv   = '0;
  coeff_t     pr [3];
  always @(posedge clk) begin
    pv    <= {pv[1:0], mul_valid_o};
    pr[0] <= coeff_t'((int'(mul_op1_o) * int'(mul_op2_o)) % QI);
    pr[1] <= pr[0];
    pr[2] <= pr[1];
  end
  assign mul_valid_i  = pv[2] & ~kill;
  assign mul_result_i = pr[2];

  // Write / event monitors.
  int wa_q [$];
  int wd_q [$];
  int done_cnt = 0;
  int mv_cnt   = 0;
  always @(negedge clk) begin
    if (wr_en_o) begin
      wa_q.push_back(int'(wr_addr_o));
      wd_q.push_back(int'(wr_data_o));
    end
    if (done_o)      done_cnt <= done_cnt + 1;
    if (mul_valid_o) mv_cnt   <= mv_cnt + 1;
  end

  int total = 0;
  int bad   = 0;
  int job_base;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      mem_a[i] = coeff_t'($urandom_range(0, QI - 1));
      mem_b[i] = coeff_t'($urandom_range(0, QI - 1));
    end
  endtask

  // Runs one job from the current cycle (called #1 after a rising edge) and
  // returns #1 after the edge following done, i.e. the first cycle in which a
  // new start can be accepted.
  task automatic do_job(input string nm, input int mid, input int rng_idx, input bit kl);
    int t0, dk, base_d, base_mv, exp_done, exp_w, nw;
    bit exp_err;
    kill     = kl;
    exp_done = kl ? N + MUL_LAT + 6 : N + 6;
    exp_w    = kl ? 0 : N;
    exp_err  = kl || (rng_idx >= 0);
    job_base = wa_q.size();
    base_d   = done_cnt;
    base_mv  = mv_cnt;
    start_i  = 1'b1;
    t0       = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk({nm, "_busy_c1"}, int'(busy_o), 1);
    chk({nm, "_rden_c1"}, int'(rd_en_o), 1);
    chk({nm, "_addr_c1"}, int'(rd_addr_o), 0);
    chk({nm, "_err_clr"}, int'(err_o), 0);
    dk = -1;
    for (int k = 1; k < N + 40; k++) begin
      start_i = (k == mid);
      if (rng_idx >= 0 && k == rng_idx + 1) chk({nm, "_err_before"}, int'(err_o), 0);
      if (rng_idx >= 0 && k == rng_idx + 2) chk({nm, "_err_at"}, int'(err_o), 1);
      if (done_o) begin
        dk = k;
        break;
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    chk({nm, "_done_cycle"}, dk, exp_done);
    if (dk >= 0) chk({nm, "_busy_at_done"}, int'(busy_o), 0);
    @(posedge clk); #1;
    nw = wa_q.size() - job_base;
    chk({nm, "_nwrites"}, nw, exp_w);
    chk({nm, "_ndone"}, done_cnt - base_d, 1);
    chk({nm, "_nmulvalid"}, mv_cnt - base_mv, N);
    chk({nm, "_err_end"}, int'(err_o), int'(exp_err));
    if (!kl && rng_idx < 0 && nw == N) begin
      for (int i = 0; i < N; i++) begin
        chk({nm, "_waddr"}, wa_q[job_base + i], i);
        chk({nm, "_wdata"}, wd_q[job_base + i], (int'(mem_a[i]) * int'(mem_b[i])) % QI);
      end
    end
    kill = 1'b0;
  endtask

  typedef struct {
    int idx;
    int a;
    int b;
    int c;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{0, 3328, 3328, 1};
    tbl[1] = '{1, 0, 1234, 0};
    tbl[2] = '{2, 1, 1, 1};
    tbl[3] = '{3, 3328, 1, 3328};
    tbl[4] = '{4, 2, 1665, 1};
    tbl[5] = '{5, 1000, 1000, 1300};

    rst     = 1'b0;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    chk("reset_err", int'(err_o), 0);
    chk("reset_wren", int'(wr_en_o), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Full job: a[i]=i, b[i]=1.
    for (int i = 0; i < N; i++) begin
      mem_a[i] = coeff_t'(i);
      mem_b[i] = 12'd1;
    end
    do_job("ramp", -1, -1, 1'b0);
    if (wa_q.size() >= job_base + N) chk("ramp_c255", wd_q[job_base + N - 1], 255);

    // Corner operands from the vector table.
    fill_random();
    foreach (tbl[t]) begin
      mem_a[tbl[t].idx] = coeff_t'(tbl[t].a);
      mem_b[tbl[t].idx] = coeff_t'(tbl[t].b);
    end
    do_job("corner", -1, -1, 1'b0);
    foreach (tbl[t]) begin
      if (wd_q.size() > job_base + tbl[t].idx)
        chk("corner_tbl", wd_q[job_base + tbl[t].idx], tbl[t].c);
      else
        chk("corner_tbl_missing", wd_q.size() - job_base, N);
    end

    // Back-to-back random jobs.
    for (int j = 0; j < 20; j++) begin
      fill_random();
      do_job("b2b", -1, -1, 1'b0);
    end

    // Stray start in cycle 50 is ignored.
    fill_random();
    do_job("midstart", 50, -1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("midstart_idle_busy", int'(busy_o), 0);

    // Reset in cycle 100 of a job.
    fill_random();
    start_i = 1'b1;
    begin
      int t0;
      int base;
      t0 = cyc;
      while (cyc - t0 < 100) begin
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      chk("rst_mid_busy_before", int'(busy_o), 1);
      rst = 1'b0;
      #1;
      chk("rst_mid_ctl", int'({busy_o, done_o, err_o, rd_en_o, mul_valid_o, wr_en_o}), 0);
      chk("rst_mid_addr", int'({rd_addr_o, wr_addr_o}), 0);
      chk("rst_mid_data", int'({mul_op1_o, mul_op2_o, wr_data_o}), 0);
      base = wa_q.size();
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_inflight_writes", wa_q.size() - base, 0);
      chk("rst_inflight_err", int'(err_o), 1);
    end
    fill_random();
    do_job("after_rst", -1, -1, 1'b0);

    // Out-of-range operand at index 7.
    fill_random();
    mem_a[7] = 12'd3329;
    do_job("range", -1, 7, 1'b0);

    // Multiplier never answers: watchdog forces DONE.
    fill_random();
    do_job("watchdog", -1, -1, 1'b1);
    fill_random();
    do_job("after_wd", -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pointwise_mul_ctrl.md
# pointwise_mul_ctrl

Sequencer that streams two N-coefficient polynomials from coefficient memory into the external `mod_mul` pipeline and writes the products back. It computes the pointwise product c[i] = a[i]·b[i] mod 3329 used by ML-KEM NTT-domain multiplication. The block sits directly upstream and downstream of `mod_mul`: it drives the multiplier's operand and valid inputs and consumes its result and valid outputs. `mod_mul` is instantiated beside this block, not inside it.

## Interface
- `N`, 256: coefficients per polynomial; power of two, ≥4.
- `MUL_LAT`, 3: `mod_mul` latency in cycles; used only for the stall-free watchdog bound.
- `ADDR_W`, $clog2(N): memory address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `start_i` in 1: one-cycle request to begin a job; sampled only in IDLE.
- `busy_o` out 1: high from the cycle after an accepted start until `done_o`.
- `done_o` out 1: one-cycle pulse after the last write.
- `err_o` out 1: sticky error flag; cleared on an accepted start.
- `rd_en_o` out 1: read strobe for both operand memories.
- `rd_addr_o` out ADDR_W: read address.
- `rd_a_i`, `rd_b_i` in 12 (`coeff_t`): synchronous read data, valid 1 cycle after `rd_en_o`.
- `mul_op1_o`, `mul_op2_o` out 12: drive `mod_mul` `op1_i`/`op2_i`.
- `mul_valid_o` out 1: drives `mod_mul` `valid_i`.
- `mul_result_i` in 12: from `mod_mul` `result_o`.
- `mul_valid_i` in 1: from `mod_mul` `valid_o`.
- `wr_en_o` out 1: result write strobe.
- `wr_addr_o` out ADDR_W: result write address.
- `wr_data_o` out 12: result data.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE → ISSUE on `start_i`.
  - ISSUE: assert `rd_en_o` every cycle with `rd_addr_o` = 0..N-1 (issue counter). Go to DRAIN after address N-1 is issued.
  - DRAIN: wait until the write counter reaches N, then go to DONE.
  - DONE: pulse `done_o` for one cycle, then return to IDLE.
- Operand path:
  - `mul_valid_o` is `rd_en_o` delayed by 1 cycle (registered).
  - `mul_op1_o`/`mul_op2_o` are wired directly from `rd_a_i`/`rd_b_i`.
  - The operands are don't-care, and driven 0, when `mul_valid_o` is low.
- Result path:
  - Each `mul_valid_i` is registered into `wr_en_o`, with `wr_data_o` = `mul_result_i` and `wr_addr_o` = write counter.
  - The write counter increments on every `mul_valid_i`; results return in issue order, so the address equals the element index.
- Range check: if `mul_valid_o` is high and either operand ≥3329, set `err_o`. The operation still proceeds; the result is whatever `mod_mul` returns.
- Protocol errors, all of which set `err_o`:
  - `mul_valid_i` while in IDLE or DONE. The result is not written.
  - More than N results in one job. The extra results are not written.
  - Watchdog: the write counter is still below N after N + MUL_LAT + 4 cycles in ISSUE/DRAIN. Set `err_o` and force DONE.
- `start_i` while not in IDLE is ignored, with no error.
- Counters are ADDR_W+1 bits so the terminal value N is representable without wrap-around.
- Reset, including in the middle of a job:
  - All outputs go to 0 and the FSM returns to IDLE; counters and `err_o` clear.
  - In-flight `mod_mul` results arriving after reset is released are treated as unexpected (`err_o`) and are not written.

## Timing
- Take the accepted `start_i` edge as cycle 0.
- `busy_o` and the first `rd_en_o` (address 0) are asserted in cycle 1.
- The last read (address N-1) is in cycle N.
- `mul_valid_o` is high in cycles 2..N+1.
- With MUL_LAT=3, `mul_valid_i` is high in cycles 5..N+4 and `wr_en_o` in cycles 6..N+5.
- `done_o` pulses in cycle N+6 and `busy_o` drops in the same cycle. A new start is accepted in cycle N+7.
- Throughput is 1 coefficient per cycle with no bubbles; total job time is N+6 cycles.

## Structure
- Shared in `poly_arith_pkg`: `coeff_t`, constant `Q = 3329`, and `N_COEFF = 256`.
- The FSM state enum is local to the block.
- No sub-module.
- The bench pairs this block with `mod_mul` and two behavioural synchronous RAMs.

## Test plan
- Full job, N=256, a[i]=i, b[i]=1 → c[i]=i. `done_o` at cycle 262, exactly 256 writes, `err_o`=0.
- Corner operands: a=3328, b=3328 at index 0 and a=0, b=1234 at index 1 → c[0]=1, c[1]=0.
- 20 back-to-back jobs with random operands in 0..3328 → each c[i] equals the golden (a·b)%3329; each new start is accepted one cycle after `done_o`.
- `start_i` pulsed in cycle 50 of a job → ignored. Exactly N writes, a single `done_o`.
- Reset asserted in cycle 100 → all outputs 0 immediately. In-flight results produce `err_o`=1 and no writes. The next start clears `err_o` and the job completes correctly.
- Operand a[7]=3329 → `err_o`=1 at cycle 9; the job still completes with `done_o`.
